event_scoreboard: RTL and testbench

//   Downstream consumer of the monitor's o_event stream. Counts checked transactions and

---
 rtl/event_scoreboard_if.sv | 34 +++
 rtl/event_scoreboard.sv | 216 +++++++++++++++++++++
 tb/tb_event_scoreboard.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/event_scoreboard_if.sv
// Event-scoreboard port bundle: run control, monitor event word, results and
// error-log handshake. The master side (test harness) drives the i_* signals,
// the slave side (scoreboard) drives the o_* signals.
interface event_scoreboard_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
);
  logic             i_start;
  logic             i_stop;
  logic [WIDTH-1:0] i_event;
  logic             o_busy;
  logic             o_done;
  logic             o_pass;
  logic [CNT_W-1:0] o_tx_count;
  logic [CNT_W-1:0] o_err_count;
  logic             o_err_seen;
  logic [CNT_W-1:0] o_first_err;
  logic             i_log_ready;
  logic             o_log_valid;
  logic [CNT_W-1:0] o_log_data;
  logic             o_log_ovf;

  modport master (
    output i_start, i_stop, i_event, i_log_ready,
    input  o_busy, o_done, o_pass, o_tx_count, o_err_count, o_err_seen,
           o_first_err, o_log_valid, o_log_data, o_log_ovf
  );

  modport slave (
    input  i_start, i_stop, i_event, i_log_ready,
    output o_busy, o_done, o_pass, o_tx_count, o_err_count, o_err_seen,
           o_first_err, o_log_valid, o_log_data, o_log_ovf
  );
endinterface

// File: rtl/event_scoreboard.sv
// Event scoreboard: scores a monitor's mismatch stream over a start/stop run
// window after a programmable warm-up, and reports pass/fail, error count and
// the index of the first failing transaction.
// Optional feature macro: SB_ERRLOG_EN builds a LOG_DEPTH-entry FIFO holding
// the tx index of every scored mismatch (LOG_DEPTH must be a power of two, >= 2).
module event_scoreboard #(
  parameter int WIDTH     = 32,
  parameter int CNT_W     = 32,
  parameter int WARMUP    = 4,
  parameter int LIMIT     = 0,
  parameter int LOG_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  event_scoreboard_if.slave  sb
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARM,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0] LIMIT_C   = CNT_W'(LIMIT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] warm_cnt_q, warm_cnt_d;
  logic [CNT_W-1:0] tx_q, tx_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] first_q, first_d;
  logic             seen_q, seen_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             mismatch;
  logic             clear;      // start accepted: wipe results and log
  logic             score_err;  // a mismatch is being scored this cycle

  assign mismatch = |sb.i_event;

  // Next-state and next-result computation for the run-window FSM.
  // NOTE: every signal gets a default at the top so no path leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    tx_d       = tx_q;
    err_d      = err_q;
    first_d    = first_q;
    seen_d     = seen_q;
    clear      = 1'b0;
    score_err  = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // Start beats a simultaneous stop; stop alone is ignored here.
        if (sb.i_start) begin
          clear      = 1'b1;
          warm_cnt_d = '0;
          tx_d       = '0;
          err_d      = '0;
          first_d    = '0;
          seen_d     = 1'b0;
          state_d    = (WARMUP == 0) ? S_RUN : S_WARM;
        end
      end
      S_WARM: begin
        // Pipeline fill: events are not looked at.
        if (sb.i_stop) begin
          state_d = S_DONE;
        end else if (warm_cnt_q == WARM_LAST) begin
          state_d = S_RUN;
        end else begin
          warm_cnt_d = warm_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (tx_q != CNT_MAX) begin
          tx_d = tx_q + 1'b1;
        end
        if (mismatch) begin
          score_err = 1'b1;
          if (err_q != CNT_MAX) begin
            err_d = err_q + 1'b1;
          end
          if (!seen_q) begin
            seen_d  = 1'b1;
            first_d = tx_q;
          end
        end
        // The stop cycle and the LIMIT-reaching cycle are both scored above.
        if (sb.i_stop || (LIMIT != 0 && tx_d == LIMIT_C)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_WARM) || (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_d == '0) && (tx_d != '0);
  end

  // Run-window state and result registers; reset aborts any run.
  // NOTE: state flops use non-blocking assignment so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      warm_cnt_q <= '0;
      tx_q       <= '0;
      err_q      <= '0;
      first_q    <= '0;
      seen_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      tx_q       <= tx_d;
      err_q      <= err_d;
      first_q    <= first_d;
      seen_q     <= seen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign sb.o_busy      = busy_q;
  assign sb.o_done      = done_q;
  assign sb.o_pass      = pass_q;
  assign sb.o_tx_count  = tx_q;
  assign sb.o_err_count = err_q;
  assign sb.o_err_seen  = seen_q;
  assign sb.o_first_err = first_q;

`ifdef SB_ERRLOG_EN
  localparam int AW = $clog2(LOG_DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] log_mem [LOG_DEPTH];
  logic             log_empty;
  logic             log_full;
  logic             log_pop;
  logic             log_wr_en;

  assign log_empty = (wr_ptr_q == rd_ptr_q);
  assign log_full  = ((wr_ptr_q - rd_ptr_q) == (AW + 1)'(LOG_DEPTH));
  assign log_pop   = !log_empty && sb.i_log_ready;

  // Log pointer/overflow update; a pop frees the slot a same-cycle push needs.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ovf_d     = ovf_q;
    log_wr_en = 1'b0;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (log_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (score_err) begin
        if (!log_full || log_pop) begin
          log_wr_en = 1'b1;
          wr_ptr_d  = wr_ptr_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  // Log pointer and overflow registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Log storage write; the entry is the pre-increment tx index.
  // NOTE: storage has no reset; entries are only visible behind the valid pointers, so reset costs nothing functionally.
  always_ff @(posedge clk) begin
    if (log_wr_en) begin
      log_mem[wr_ptr_q[AW-1:0]] <= tx_q;
    end
  end

  assign sb.o_log_valid = !log_empty;
  assign sb.o_log_data  = log_empty ? '0 : log_mem[rd_ptr_q[AW-1:0]];
  assign sb.o_log_ovf   = ovf_q;
`else
  logic unused_log;
  assign unused_log = &{1'b0, sb.i_log_ready, clear, score_err, LOG_DEPTH[0]};

  assign sb.o_log_valid = 1'b0;
  assign sb.o_log_data  = '0;
  assign sb.o_log_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_event_scoreboard.sv
// Testbench for event_scoreboard. Two instances share one stimulus stream:
// dut_a (WARMUP=4, LIMIT=0) and dut_b (WARMUP=0, LIMIT=16). A window-age
// reference model predicts every output each cycle; a hand-written vector
// table and directed sequences pin down the corner cases.
module tb_event_scoreboard;

  localparam int LOG_DEPTH = 8;

  logic        clk;
  logic        reset;
  logic        tb_start;
  logic        tb_stop;
  logic [31:0] tb_event;
  logic        tb_ready;

  int n_checks;
  int n_errors;

  event_scoreboard_if #(.WIDTH(32), .CNT_W(32)) if_a ();
  event_scoreboard_if #(.WIDTH(32), .CNT_W(32)) if_b ();

  assign if_a.i_start     = tb_start;
  assign if_a.i_stop      = tb_stop;
  assign if_a.i_event     = tb_event;
  assign if_a.i_log_ready = tb_ready;
  assign if_b.i_start     = tb_start;
  assign if_b.i_stop      = tb_stop;
  assign if_b.i_event     = tb_event;
  assign if_b.i_log_ready = tb_ready;

  event_scoreboard #(.WIDTH(32), .CNT_W(32), .WARMUP(4), .LIMIT(0), .LOG_DEPTH(LOG_DEPTH))
    dut_a (.clk(clk), .reset(reset), .sb(if_a.slave));
  event_scoreboard #(.WIDTH(32), .CNT_W(32), .WARMUP(0), .LIMIT(16), .LOG_DEPTH(LOG_DEPTH))
    dut_b (.clk(clk), .reset(reset), .sb(if_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a run is "active" from an accepted start until it ends;
  // cycles with age >= warm-up are scored.
  typedef struct {
    bit          active;
    bit          ended;
    int unsigned age;
    logic [31:0] tx;
    logic [31:0] err;
    logic [31:0] first;
    bit          seen;
  } mdl_t;

  mdl_t        ma, mb;
  logic [31:0] log_q [$];
  bit          log_ovf_m;

  function automatic mdl_t mdl_step(input mdl_t m, input bit st, input bit sp, input bit mis,
                                    input int unsigned warm, input int unsigned lim,
                                    output bit push, output logic [31:0] idx, output bit clr);
    push = 1'b0;
    idx  = '0;
    clr  = 1'b0;
    if (!m.active) begin
      if (st) begin
        m = '{default: 0};
        m.active = 1'b1;
        clr = 1'b1;
      end
    end else begin
      if (m.age >= warm) begin
        idx = m.tx;
        if (mis) begin
          push = 1'b1;
          if (m.err != 32'hFFFF_FFFF) m.err = m.err + 1;
          if (!m.seen) begin
            m.seen  = 1'b1;
            m.first = m.tx;
          end
        end
        if (m.tx != 32'hFFFF_FFFF) m.tx = m.tx + 1;
        if (lim != 0 && m.tx == lim) m.active = 1'b0;
      end else begin
        m.age = m.age + 1;
      end
      if (sp) m.active = 1'b0;
      if (!m.active) m.ended = 1'b1;
    end
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit da, db;
    da = ma.ended && !ma.active;
    db = mb.ended && !mb.active;
    check("a.busy",  if_a.o_busy,      ma.active);
    check("a.done",  if_a.o_done,      da);
    check("a.pass",  if_a.o_pass,      da && ma.err == 0 && ma.tx != 0);
    check("a.tx",    if_a.o_tx_count,  ma.tx);
    check("a.err",   if_a.o_err_count, ma.err);
    check("a.seen",  if_a.o_err_seen,  ma.seen);
    check("a.first", if_a.o_first_err, ma.first);
    check("a.lvld",  if_a.o_log_valid, log_q.size() != 0);
    check("a.ldata", if_a.o_log_data,  (log_q.size() != 0) ? log_q[0] : 32'd0);
    check("a.lovf",  if_a.o_log_ovf,   log_ovf_m);
    check("b.busy",  if_b.o_busy,      mb.active);
    check("b.done",  if_b.o_done,      db);
    check("b.pass",  if_b.o_pass,      db && mb.err == 0 && mb.tx != 0);
    check("b.tx",    if_b.o_tx_count,  mb.tx);
    check("b.err",   if_b.o_err_count, mb.err);
    check("b.seen",  if_b.o_err_seen,  mb.seen);
    check("b.first", if_b.o_first_err, mb.first);
  endtask

  // One clock: drive inputs, step both models at the edge, compare 1 ns later.
  task automatic cycle(input bit st, input bit sp, input logic [31:0] ev, input bit rdy);
    bit          pop, pa, pb, ca, cb;
    logic [31:0] ia, ib;
    tb_start = st;
    tb_stop  = sp;
    tb_event = ev;
    tb_ready = rdy;
    pop = rdy && (log_q.size() != 0);
    @(posedge clk);
    ma = mdl_step(ma, st, sp, ev != 0, 4, 0, pa, ia, ca);
    mb = mdl_step(mb, st, sp, ev != 0, 0, 16, pb, ib, cb);
`ifdef SB_ERRLOG_EN
    if (pop) void'(log_q.pop_front());
    if (pa) begin
      if (log_q.size() < LOG_DEPTH) log_q.push_back(ia);
      else log_ovf_m = 1'b1;
    end
    if (ca) begin
      log_q.delete();
      log_ovf_m = 1'b0;
    end
`else
    if (pop || pa || ca || pb || cb || ib != ia) begin end
`endif
    #1;
    compare_all();
  endtask

  typedef struct {
    bit          st;
    bit          sp;
    logic [31:0] ev;
    bit          busy;
    bit          done;
    bit          pass;
    logic [31:0] tx;
    logic [31:0] err;
    logic [31:0] first;
    bit          seen;
  } vec_t;

  vec_t vecs [15];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    tb_start  = 1'b0;
    tb_stop   = 1'b0;
    tb_event  = '0;
    tb_ready  = 1'b0;
    ma        = '{default: 0};
    mb        = '{default: 0};
    log_ovf_m = 1'b0;

    //           st sp ev  busy done pass tx err first seen   (dut_a, WARMUP=4)
    vecs[0]  = '{1, 0, 0,  1, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 5,  1, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0,  1, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 0,  1, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 1,  1, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{0, 0, 0,  1, 0, 0, 1, 0, 0, 0};
    vecs[6]  = '{0, 0, 3,  1, 0, 0, 2, 1, 1, 1};
    vecs[7]  = '{0, 0, 0,  1, 0, 0, 3, 1, 1, 1};
    vecs[8]  = '{0, 1, 1,  0, 1, 0, 4, 2, 1, 1};
    vecs[9]  = '{0, 0, 7,  0, 1, 0, 4, 2, 1, 1};
    vecs[10] = '{0, 1, 0,  0, 1, 0, 4, 2, 1, 1};
    vecs[11] = '{1, 1, 0,  1, 0, 0, 0, 0, 0, 0};
    vecs[12] = '{0, 1, 0,  0, 1, 0, 0, 0, 0, 0};
    vecs[13] = '{1, 0, 0,  1, 0, 0, 0, 0, 0, 0};
    vecs[14] = '{0, 1, 9,  0, 1, 0, 0, 0, 0, 0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b1;

    // Vector table.
    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].st, vecs[i].sp, vecs[i].ev, 1'b0);
      check($sformatf("vec%0d.busy", i),  if_a.o_busy,      vecs[i].busy);
      check($sformatf("vec%0d.done", i),  if_a.o_done,      vecs[i].done);
      check($sformatf("vec%0d.pass", i),  if_a.o_pass,      vecs[i].pass);
      check($sformatf("vec%0d.tx", i),    if_a.o_tx_count,  vecs[i].tx);
      check($sformatf("vec%0d.err", i),   if_a.o_err_count, vecs[i].err);
      check($sformatf("vec%0d.first", i), if_a.o_first_err, vecs[i].first);
      check($sformatf("vec%0d.seen", i),  if_a.o_err_seen,  vecs[i].seen);
    end

    // Clean run: warm-up events ignored, stop cycle scored -> tx=11, pass.
    cycle(1, 0, 0, 0);
    repeat (4) cycle(0, 0, 1, 0);
    repeat (10) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    check("clean.tx",   if_a.o_tx_count,  32'd11);
    check("clean.err",  if_a.o_err_count, 32'd0);
    check("clean.pass", if_a.o_pass,      1'b1);
    check("clean.seen", if_a.o_err_seen,  1'b0);

    // Errors at tx 3, 7, 8 over a 20-cycle run.
    cycle(1, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(0, i == 19, (i == 3 || i == 7 || i == 8) ? 32'(i + 1) : 32'd0, 0);
    end
    check("errs.tx",    if_a.o_tx_count,  32'd20);
    check("errs.err",   if_a.o_err_count, 32'd3);
    check("errs.first", if_a.o_first_err, 32'd3);
    check("errs.seen",  if_a.o_err_seen,  1'b1);
    check("errs.pass",  if_a.o_pass,      1'b0);

    // LIMIT=16 on dut_b: auto-stop, later events ignored.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 22; i++) cycle(0, 0, (i % 2 == 1) ? 32'h80 : 32'd0, 0);
    check("limit.tx",   if_b.o_tx_count,  32'd16);
    check("limit.done", if_b.o_done,      1'b1);
    check("limit.err",  if_b.o_err_count, 32'd8);
    cycle(0, 1, 0, 0);

    // Reset asserted mid-run after 5 errors.
    cycle(1, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 0);
    repeat (5) cycle(0, 0, 32'h2, 0);
    check("rst.err_before", if_a.o_err_count, 32'd5);
    #2;
    reset = 1'b0;
    #1;
    ma = '{default: 0};
    mb = '{default: 0};
    log_q.delete();
    log_ovf_m = 1'b0;
    compare_all();
    check("rst.err",  if_a.o_err_count, 32'd0);
    check("rst.busy", if_a.o_busy,      1'b0);
    @(negedge clk);
    reset = 1'b1;
    cycle(1, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);
    check("rst.restart_tx", if_a.o_tx_count, 32'd3);
    cycle(0, 1, 0, 0);

    // Error log: 10 mismatches with no reader, then drain.
    begin
      int k;
      k = 0;
      cycle(1, 0, 0, 0);
      repeat (4) cycle(0, 0, 0, 0);
      repeat (10) cycle(0, 0, 32'h1, 0);
      cycle(0, 1, 0, 0);
      for (int i = 0; i < 10; i++) begin
`ifdef SB_ERRLOG_EN
        if (if_a.o_log_valid) begin
          check("log.order", if_a.o_log_data, 32'(k));
          k++;
        end
`endif
        cycle(0, 0, 0, 1);
      end
`ifdef SB_ERRLOG_EN
      check("log.count", 32'(k), 32'd8);
      check("log.ovf",   if_a.o_log_ovf,   1'b1);
      check("log.empty", if_a.o_log_valid, 1'b0);
`endif
    end

    // Randomized stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
            ($urandom_range(0, 3) == 0) ? $urandom : 32'd0, $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
